host_mem_sequencer: RTL and testbench

- Hardware replacement for bench-driven memory loading. Sequences external IRAM/DRAM loading, processor start and DRAM readback through the existing addr_ext / write-enable / start_2/3/4 mode interface of top_control.
- Generalised to N cores, parametrised data and address widths, and configurable write-strobe and read-latency timing.
- Sits between a host stream interface (UART/JTAG bridge) and the processor top level.

---
 rtl/host_mem_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_host_mem_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/host_mem_sequencer.sv
// Host-driven sequencer for IRAM/DRAM loading, core start and DRAM readback through the
// addr_ext / write-enable / start_2/3/4 mode interface of the processor top level.
module host_mem_sequencer #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned ADDR_W      = 9,
  parameter int unsigned N_CORES     = 1,
  parameter int unsigned WR_HOLD     = 4,
  parameter int unsigned RD_LAT      = 5,
  parameter int unsigned RUN_TIMEOUT = 120000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [N_CORES-1:0] cmd_core,
  input  logic [ADDR_W-1:0]  cmd_base,
  input  logic [ADDR_W-1:0]  cmd_len,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [DATA_W-1:0]  wr_data,
  output logic               rd_valid,
  input  logic               rd_ready,
  output logic [DATA_W-1:0]  rd_data,
  output logic [ADDR_W-1:0]  addr_ext,
  output logic [DATA_W-1:0]  data_ext,
  output logic [N_CORES-1:0] iram_write_ext,
  output logic               dram_write_ext,
  output logic               read_en_ext,
  input  logic [DATA_W-1:0]  dram_in,
  output logic               start_2,
  output logic               start_3,
  output logic               start_4,
  output logic [N_CORES-1:0] start,
  input  logic [N_CORES-1:0] proc_done,
  output logic               busy,
  output logic               error
);

  localparam logic [3:0] IDLE       = 4'd0;
  localparam logic [3:0] LD_WAIT    = 4'd1;
  localparam logic [3:0] LD_SETUP   = 4'd2;
  localparam logic [3:0] LD_STROBE  = 4'd3;
  localparam logic [3:0] LD_RELEASE = 4'd4;
  localparam logic [3:0] RUN        = 4'd5;
  localparam logic [3:0] RB_READ    = 4'd6;
  localparam logic [3:0] RB_WAIT    = 4'd7;
  localparam logic [3:0] RB_OUT     = 4'd8;
  localparam logic [3:0] RB_NEXT    = 4'd9;

  localparam logic [1:0] OP_IRAM = 2'd0;
  localparam logic [1:0] OP_DRAM = 2'd1;
  localparam logic [1:0] OP_RUN  = 2'd2;
  localparam logic [1:0] OP_RB   = 2'd3;

  logic [3:0]         state;
  logic [1:0]         op;
  logic [N_CORES-1:0] core;
  logic [ADDR_W-1:0]  len;
  logic [ADDR_W-1:0]  cnt;
  logic [31:0]        tmr;
  logic               rdy;
  logic               accept;
  logic               noop;
  logic               last;
  logic [N_CORES-1:0] core_lo;

  assign accept  = cmd_valid && cmd_ready;
  assign last    = (cnt == len - 1'b1);
  // IRAM loads target only the lowest selected core.
  assign core_lo = cmd_core & (~cmd_core + N_CORES'(1));

  always_comb begin
    noop = 1'b0;
    if (cmd_op != OP_RUN && cmd_len == '0) noop = 1'b1;
    if ((cmd_op == OP_IRAM || cmd_op == OP_RUN) && cmd_core == '0) noop = 1'b1;
  end

  assign cmd_ready      = rdy && (state == IDLE);
  assign busy           = (state != IDLE);
  assign wr_ready       = (state == LD_WAIT);
  assign iram_write_ext = (state == LD_STROBE && op == OP_IRAM) ? core : '0;
  assign dram_write_ext = (state == LD_STROBE && op == OP_DRAM);
  assign read_en_ext    = (state == RB_READ) || (state == RB_WAIT);
  assign rd_valid       = (state == RB_OUT);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      op       <= OP_IRAM;
      core     <= '0;
      len      <= '0;
      cnt      <= '0;
      tmr      <= '0;
      rdy      <= 1'b0;
      addr_ext <= '0;
      data_ext <= '0;
      rd_data  <= '0;
      start_2  <= 1'b0;
      start_3  <= 1'b0;
      start_4  <= 1'b0;
      start    <= '0;
      error    <= 1'b0;
    end else begin
      rdy <= 1'b1;
      case (state)
        IDLE: begin
          if (accept && cmd_op == OP_RUN) error <= 1'b0;
          if (accept && !noop) begin
            op       <= cmd_op;
            core     <= (cmd_op == OP_IRAM) ? core_lo : cmd_core;
            len      <= cmd_len;
            cnt      <= '0;
            tmr      <= '0;
            addr_ext <= cmd_base;
            case (cmd_op)
              OP_IRAM: begin start_2 <= 1'b1; state <= LD_WAIT; end
              OP_DRAM: begin start_3 <= 1'b1; state <= LD_WAIT; end
              OP_RUN:  begin start   <= cmd_core; state <= RUN; end
              default: begin start_4 <= 1'b1; state <= RB_READ; end
            endcase
          end
        end
        LD_WAIT: begin
          if (wr_valid) begin
            data_ext <= wr_data;
            state    <= LD_SETUP;
          end
        end
        LD_SETUP: begin
          tmr   <= '0;
          state <= LD_STROBE;
        end
        LD_STROBE: begin
          if (tmr == WR_HOLD - 1) state <= LD_RELEASE;
          else tmr <= tmr + 1;
        end
        LD_RELEASE: begin
          addr_ext <= addr_ext + 1'b1;
          cnt      <= cnt + 1'b1;
          if (last) begin
            start_2 <= 1'b0;
            start_3 <= 1'b0;
            state   <= IDLE;
          end else begin
            state <= LD_WAIT;
          end
        end
        RUN: begin
          if ((proc_done & core) == core) begin
            start <= '0;
            state <= IDLE;
          end else if (RUN_TIMEOUT != 0 && tmr == RUN_TIMEOUT - 1) begin
            start <= '0;
            error <= 1'b1;
            state <= IDLE;
          end else begin
            tmr <= tmr + 1;
          end
        end
        RB_READ: begin
          tmr   <= '0;
          state <= RB_WAIT;
        end
        RB_WAIT: begin
          if (tmr == RD_LAT - 1) begin
            rd_data <= dram_in;
            state   <= RB_OUT;
          end else begin
            tmr <= tmr + 1;
          end
        end
        RB_OUT: begin
          if (rd_ready) state <= RB_NEXT;
        end
        RB_NEXT: begin
          addr_ext <= addr_ext + 1'b1;
          cnt      <= cnt + 1'b1;
          if (last) begin
            start_4 <= 1'b0;
            state   <= IDLE;
          end else begin
            state <= RB_READ;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_host_mem_sequencer.sv
// Directed self-checking bench for host_mem_sequencer: loads, run/timeout, readback,
// reset mid-operation and zero-length commands.
module tb_host_mem_sequencer;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 9;
  localparam int unsigned NC = 2;
  localparam int unsigned WH = 4;
  localparam int unsigned RL = 5;
  localparam int unsigned RT = 400;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = '0;
  logic [NC-1:0] cmd_core = '0;
  logic [AW-1:0] cmd_base = '0;
  logic [AW-1:0] cmd_len = '0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [DW-1:0] wr_data = '0;
  logic          rd_valid;
  logic          rd_ready = 1'b0;
  logic [DW-1:0] rd_data;
  logic [AW-1:0] addr_ext;
  logic [DW-1:0] data_ext;
  logic [NC-1:0] iram_write_ext;
  logic          dram_write_ext;
  logic          read_en_ext;
  logic [DW-1:0] dram_in;
  logic          start_2, start_3, start_4;
  logic [NC-1:0] start;
  logic [NC-1:0] proc_done = '0;
  logic          busy;
  logic          error;

  always #5 clock = ~clock;

  host_mem_sequencer #(
    .DATA_W(DW), .ADDR_W(AW), .N_CORES(NC), .WR_HOLD(WH), .RD_LAT(RL), .RUN_TIMEOUT(RT)
  ) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_core(cmd_core),
    .cmd_base(cmd_base), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .addr_ext(addr_ext), .data_ext(data_ext), .iram_write_ext(iram_write_ext),
    .dram_write_ext(dram_write_ext), .read_en_ext(read_en_ext), .dram_in(dram_in),
    .start_2(start_2), .start_3(start_3), .start_4(start_4), .start(start),
    .proc_done(proc_done), .busy(busy), .error(error)
  );

  // DRAM model: data valid only once read_en_ext has been high for RL cycles.
  logic [DW-1:0] dram_mem [512];
  int rcnt = 0;
  always @(negedge clock) begin
    if (read_en_ext) rcnt <= rcnt + 1;
    else rcnt <= 0;
  end
  assign dram_in = (rcnt >= int'(RL) + 1) ? dram_mem[addr_ext] : 16'hDEAD;

  // Write-pulse recorder and protocol invariants.
  logic [2:0]    p_en;
  logic [AW-1:0] p_addr;
  logic [DW-1:0] p_data;
  logic [2:0]    p_mode;
  int hi_cnt = 0, nw = 0, viol = 0, n_s2 = 0, n_s3 = 0, n_s4 = 0;
  logic [2:0]    w_en   [64];
  logic [AW-1:0] w_addr [64];
  logic [DW-1:0] w_data [64];
  int            w_len  [64];

  always @(negedge clock) begin
    if (reset) begin
      hi_cnt <= 0;
    end else begin
      if ({dram_write_ext, iram_write_ext} != 3'b0) begin
        if (hi_cnt == 0) begin
          p_en   <= {dram_write_ext, iram_write_ext};
          p_addr <= addr_ext;
          p_data <= data_ext;
          p_mode <= {start_4, start_3, start_2};
        end else if ({dram_write_ext, iram_write_ext} != p_en || addr_ext != p_addr ||
                     data_ext != p_data || {start_4, start_3, start_2} != p_mode) begin
          viol <= viol + 1;
        end
        hi_cnt <= hi_cnt + 1;
      end else if (hi_cnt != 0) begin
        if (nw < 64) begin
          w_en[nw]   <= p_en;
          w_addr[nw] <= p_addr;
          w_data[nw] <= p_data;
          w_len[nw]  <= hi_cnt;
        end
        nw     <= nw + 1;
        hi_cnt <= 0;
      end
      if (start_2) n_s2 <= n_s2 + 1;
      if (start_3) n_s3 <= n_s3 + 1;
      if (start_4) n_s4 <= n_s4 + 1;
      if (int'(start_2) + int'(start_3) + int'(start_4) > 1) viol <= viol + 1;
      if ((start_2 || start_3 || start_4) && start != '0) viol <= viol + 1;
      if (rd_valid && read_en_ext) viol <= viol + 1;
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [NC-1:0] core,
                          input logic [AW-1:0] base, input logic [AW-1:0] len);
    int k = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_core = core; cmd_base = base; cmd_len = len;
    while (!cmd_ready && k < 20) begin tick(); k++; end
    check("cmd_ready", 32'(cmd_ready), 1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic send_word(input logic [DW-1:0] d);
    int k = 0;
    wr_valid = 1'b1; wr_data = d;
    while (!wr_ready && k < 40) begin tick(); k++; end
    check("wr_ready", 32'(wr_ready), 1);
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 1000) begin tick(); n++; end
    check("idle", 32'(busy), 0);
  endtask

  task automatic check_rec(input string tag, input int idx, input logic [2:0] en,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
    check({tag, "_en"}, 32'(w_en[idx]), 32'(en));
    check({tag, "_addr"}, 32'(w_addr[idx]), 32'(a));
    check({tag, "_data"}, 32'(w_data[idx]), 32'(d));
    check({tag, "_len"}, w_len[idx], WH);
  endtask

  initial begin
    int n, c, b, first0, s2b, s3b, s4b, unstable;
    logic [DW-1:0] words [4];

    dram_mem[100] = 16'hBEEF;
    dram_mem[101] = 16'h1234;

    // Reset state
    repeat (3) tick();
    check("rst_outputs", {iram_write_ext, dram_write_ext, read_en_ext, start_2, start_3, start_4,
                          start, busy, cmd_ready, wr_ready, rd_valid, error}, 0);
    reset = 1'b0;
    check("rdy_after_release", 32'(cmd_ready), 0);
    tick();
    check("rdy_first_clock", 32'(cmd_ready), 1);

    // 1: LOAD_IRAM base 1 len 3
    b = nw; s2b = n_s2; s3b = n_s3; s4b = n_s4;
    send_cmd(2'd0, 2'b01, 9'd1, 9'd3);
    check("t1_start2", 32'(start_2), 1);
    check("t1_busy", 32'(busy), 1);
    send_word(16'd10); send_word(16'd20); send_word(16'd30);
    wait_idle(n);
    check("t1_tail", n, WH + 2);
    check("t1_count", nw - b, 3);
    check_rec("t1_w0", b, 3'b001, 9'd1, 16'd10);
    check_rec("t1_w1", b + 1, 3'b001, 9'd2, 16'd20);
    check_rec("t1_w2", b + 2, 3'b001, 9'd3, 16'd30);
    check("t1_s2_seen", 32'((n_s2 - s2b) != 0), 1);
    check("t1_s3s4", (n_s3 - s3b) + (n_s4 - s4b), 0);

    // 2: LOAD_DRAM base 510 len 4, wrap past 511
    b = nw; s2b = n_s2; s3b = n_s3;
    words[0] = 16'hA001; words[1] = 16'hA002; words[2] = 16'hA003; words[3] = 16'hA004;
    send_cmd(2'd1, 2'b00, 9'd510, 9'd4);
    for (int i = 0; i < 4; i++) send_word(words[i]);
    wait_idle(n);
    check("t2_tail", n, WH + 2);
    check("t2_count", nw - b, 4);
    check_rec("t2_w0", b, 3'b100, 9'd510, 16'hA001);
    check_rec("t2_w1", b + 1, 3'b100, 9'd511, 16'hA002);
    check_rec("t2_w2", b + 2, 3'b100, 9'd0, 16'hA003);
    check_rec("t2_w3", b + 3, 3'b100, 9'd1, 16'hA004);
    check("t2_s3_seen", 32'((n_s3 - s3b) != 0), 1);
    check("t2_no_s2", n_s2 - s2b, 0);

    // 6: zero-length and empty-mask commands are no-ops
    b = nw; s2b = n_s2; s3b = n_s3; s4b = n_s4;
    send_cmd(2'd1, 2'b01, 9'd20, 9'd0);
    check("t6_len0_busy", 32'(busy), 0);
    send_cmd(2'd0, 2'b00, 9'd20, 9'd5);
    check("t6_mask0_busy", 32'(busy), 0);
    send_cmd(2'd2, 2'b00, 9'd0, 9'd0);
    check("t6_run0_start", {31'd0, busy} | 32'(start), 0);
    repeat (3) tick();
    check("t6_no_writes", nw - b, 0);
    check("t6_no_modes", (n_s2 - s2b) + (n_s3 - s3b) + (n_s4 - s4b), 0);

    // 3a: RUN both cores, done at 100 and 300
    send_cmd(2'd2, 2'b11, 9'd0, 9'd0);
    check("t3_start", 32'(start), 32'b11);
    first0 = -1;
    c = 0;
    while (first0 < 0 && c < 1000) begin
      if (c == 150) check("t3_start_mid", 32'(start), 32'b11);
      if (start == '0) first0 = c;
      else begin
        if (c == 100) proc_done[0] = 1'b1;
        if (c == 300) proc_done[1] = 1'b1;
        tick();
        c++;
      end
    end
    check("t3_done_cycle", first0, 301);
    check("t3_error", 32'(error), 0);
    check("t3_busy", 32'(busy), 0);
    proc_done = '0;

    // 3b: RUN timeout
    send_cmd(2'd2, 2'b01, 9'd0, 9'd0);
    c = 0;
    while (start != '0 && c < 1000) begin tick(); c++; end
    check("t3_timeout_cycle", c, RT);
    check("t3_timeout_error", 32'(error), 1);

    // 3c: next RUN clears the sticky error
    proc_done = 2'b01;
    send_cmd(2'd2, 2'b01, 9'd0, 9'd0);
    check("t3_err_clear", 32'(error), 0);
    check("t3_start_c", 32'(start), 32'b01);
    tick();
    check("t3_quick_done", {31'd0, busy} | 32'(start), 0);
    proc_done = '0;

    // 4: READBACK base 100 len 2 with backpressure
    s2b = n_s2; s3b = n_s3; s4b = n_s4;
    rd_ready = 1'b0;
    send_cmd(2'd3, 2'b00, 9'd100, 9'd2);
    check("t4_start4", 32'(start_4), 1);
    c = 0;
    while (!rd_valid && c < 50) begin tick(); c++; end
    check("t4_lat0", c, RL + 1);
    check("t4_data0", 32'(rd_data), 32'hBEEF);
    check("t4_ren_low", 32'(read_en_ext), 0);
    unstable = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!rd_valid || rd_data != 16'hBEEF) unstable++;
    end
    check("t4_hold", unstable, 0);
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    c = 0;
    while (!rd_valid && c < 50) begin tick(); c++; end
    check("t4_lat1", c, RL + 2);
    check("t4_data1", 32'(rd_data), 32'h1234);
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    wait_idle(n);
    check("t4_tail", n, 1);
    check("t4_s4_seen", 32'((n_s4 - s4b) != 0), 1);
    check("t4_no_s2s3", (n_s2 - s2b) + (n_s3 - s3b), 0);

    // 5: reset during the strobe of word 2
    b = nw;
    send_cmd(2'd0, 2'b10, 9'd5, 9'd3);
    send_word(16'h0111);
    send_word(16'h0222);
    tick(); tick();
    check("t5_strobe", 32'(iram_write_ext), 32'b10);
    reset = 1'b1;
    #1;
    check("t5_async_zero", {iram_write_ext, dram_write_ext, read_en_ext, start_2, start_3,
                            start_4, start, busy, cmd_ready, wr_ready, rd_valid, error}, 0);
    check("t5_async_addr", {7'd0, addr_ext, data_ext}, 0);
    tick(); tick();
    reset = 1'b0;
    check("t5_busy", 32'(busy), 0);
    tick();
    check("t5_ready", 32'(cmd_ready), 1);
    check("t5_partial", nw - b, 1);
    check_rec("t5_w0", b, 3'b010, 9'd5, 16'h0111);
    send_cmd(2'd1, 2'b00, 9'd7, 9'd1);
    send_word(16'h0055);
    wait_idle(n);
    check("t5_after", nw - b, 2);
    check_rec("t5_w1", b + 1, 3'b100, 9'd7, 16'h0055);

    check("invariants", viol, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
